// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush scheduler for the 5-stage pipeline
// Covers load-use bubbles, taken-branch squash, dmem freeze with timeout, and saturating perf counters.
module pipeline_hazard_ctrl #(
    parameter int WAIT_TIMEOUT = 255,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs1ID,
    input  logic [4:0]       rs2ID,
    input  logic             useRs1ID,
    input  logic             useRs2ID,
    input  logic [4:0]       rdEX,
    input  logic             lwEX,
    input  logic             branchTakenEX,
    input  logic             memReq,
    input  logic             memReady,
    output logic             pcEn,
    output logic             ifidEn,
    output logic             idexEn,
    output logic             exmemEn,
    output logic             memwbEn,
    output logic             ifidFlush,
    output logic             idexFlush,
    output logic             memError,
    output logic [CNT_W-1:0] stallCnt,
    output logic [CNT_W-1:0] flushCnt
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;
    state_t state, state_next;
    logic [7:0] wait_cnt, wait_next;
    logic mem_stall, load_use, stall_inc;
    assign mem_stall = memReq & ~memReady;
    assign load_use = lwEX & (rdEX != 5'd0) &
                      ((useRs1ID & (rs1ID == rdEX)) | (useRs2ID & (rs2ID == rdEX)));
    assign stall_inc = (state != HALT) & ~pcEn;
    always_comb begin
        {pcEn, ifidEn, idexEn, exmemEn, memwbEn, ifidFlush, idexFlush} = 7'b0;
        state_next = state;
        wait_next = wait_cnt;
        // A branch held in EX during a freeze keeps requesting, so it flushes once on release.
        if (!reset && state != HALT && !mem_stall) begin
            {idexEn, exmemEn, memwbEn} = 3'b111;
            pcEn = branchTakenEX | ~load_use;
            ifidEn = branchTakenEX | ~load_use;
            ifidFlush = branchTakenEX;
            idexFlush = branchTakenEX | load_use;
        end
        case (state)
            RUN: begin
                if (mem_stall) begin
                    state_next = MEM_WAIT;
                    wait_next = 8'd1;
                end
            end
            MEM_WAIT: begin
                if (memReady) begin
                    state_next = RUN;
                    wait_next = 8'd0;
                end else if (wait_cnt == 8'(WAIT_TIMEOUT)) begin
                    state_next = HALT;
                end else begin
                    wait_next = wait_cnt + 8'd1;
                end
            end
            default: ;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            wait_cnt <= 8'd0;
            memError <= 1'b0;
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            state <= state_next;
            wait_cnt <= wait_next;
            if (state_next == HALT) memError <= 1'b1;
            if (stall_inc && stallCnt != '1) stallCnt <= stallCnt + CNT_W'(1);
            if (ifidFlush && flushCnt != '1) flushCnt <= flushCnt + CNT_W'(1);
        end
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush scheduler for the 5-stage RISC-V pipeline. Detects load-use hazards that forwarding cannot cover, squashes wrong-path instructions on taken branches, and freezes the pipeline while the data memory handshake is outstanding. It drives the enable/flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB, and keeps saturating stall/flush performance counters.

## Interface
- WAIT_TIMEOUT, 255: max consecutive freeze cycles waiting on mem_ready before HALT (1..255).
- CNT_W, 16: width of performance counters.

- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high.
- rs1ID, rs2ID  in  5  source registers of the instruction in ID.
- useRs1ID, useRs2ID  in  1  ID instruction actually reads rs1/rs2.
- rdEX  in  5  destination of the instruction in EX.
- lwEX  in  1  EX instruction is a load.
- branchTakenEX  in  1  EX resolved a taken branch/jump (PC redirect).
- memReq  in  1  MEM instruction accesses data memory.
- memReady  in  1  data memory completes the access this cycle.
- pcEn, ifidEn, idexEn, exmemEn, memwbEn  out  1 each  register enables (1 = advance).
- ifidFlush, idexFlush  out  1 each  synchronous clear to bubble of IF/ID, ID/EX.
- memError  out  1  sticky: memory timeout occurred, pipeline halted.
- stallCnt  out  CNT_W  cycles with pcEn=0 in RUN/MEM_WAIT.
- flushCnt  out  CNT_W  cycles with a branch flush.

## Operation
- FSM states: RUN, MEM_WAIT, HALT. Internal wait counter waitCnt, 8 bits.
- Definitions: memStall = memReq & !memReady. loadUse = lwEX & (rdEX != 0) & ((useRs1ID & rs1ID == rdEX) | (useRs2ID & rs2ID == rdEX)).
- Control decode (combinational, RUN and MEM_WAIT), strict priority:
  1. memStall: freeze — all five enables 0, both flushes 0.
  2. branchTakenEX: all enables 1, ifidFlush=1, idexFlush=1.
  3. loadUse: pcEn=0, ifidEn=0, idexEn/exmemEn/memwbEn=1, idexFlush=1 (bubble into EX), ifidFlush=0.
  4. otherwise: all enables 1, no flush.
- Branch during freeze: flush suppressed; since EX is held, branchTakenEX stays high and the flush fires on the first non-frozen cycle, exactly once.
- Branch with loadUse in same cycle: branch wins; the loaded-consumer in ID is squashed anyway.
- Transitions:
  - RUN: memStall -> MEM_WAIT, waitCnt<=1; else stay.
  - MEM_WAIT: memReady -> RUN, waitCnt<=0; else if waitCnt == WAIT_TIMEOUT -> HALT, memError<=1; else waitCnt<=waitCnt+1.
  - HALT: absorbing until reset. All enables 0, flushes 0, memError=1.
- Counters: stallCnt += 1 on any RUN/MEM_WAIT cycle with pcEn=0; flushCnt += 1 on each cycle ifidFlush=1. Both saturate at all-ones; no wrap.
- rdEX = x0 never triggers a load-use stall.

## Timing
- Reset (asynchronous, immediate): state=RUN, waitCnt=0, memError=0, stallCnt=0, flushCnt=0; while reset is high all enables 0 and flushes 0.
- All control outputs are combinational from state and inputs, valid in the same cycle; zero latency.
- Load-use costs exactly 1 bubble: cycle N stall, cycle N+1 the load is in MEM and loadUse deasserts.
- Memory wait of k cycles (memReady first high in cycle k+1 after request) freezes exactly k cycles; the cycle memReady=1 advances normally.
- Timeout: HALT entered on the edge after the WAIT_TIMEOUT-th MEM_WAIT cycle with memReady still 0; memError visible next cycle.
- Reset mid-MEM_WAIT or in HALT returns to RUN and clears all state asynchronously.

## Test plan
- Load-use: lwEX=1, rdEX=5, rs1ID=5, useRs1ID=1 for one cycle -> pcEn=0, ifidEn=0, idexFlush=1, stallCnt 0->1; rdEX=0 same inputs -> no stall.
- Taken branch: branchTakenEX=1 with concurrent loadUse -> ifidFlush=idexFlush=1, pcEn=1, flushCnt +1, stallCnt unchanged.
- Memory wait: memReq=1, memReady=0 for 3 cycles then 1 -> enables 0 for exactly 3 cycles, state MEM_WAIT, RUN after; stallCnt +3.
- Branch under freeze: branchTakenEX=1 held during 2-cycle memStall -> no flush during freeze, single flush on release cycle, flushCnt +1.
- Timeout: WAIT_TIMEOUT=4, memReady held 0 -> HALT after 4 wait cycles, memError=1, enables stuck 0; assert reset mid-HALT -> RUN, counters 0, memError 0.
- Saturation: CNT_W=4, 20 load-use stall cycles -> stallCnt stops at 15.
